ahb2apb_bridge_param: RTL

Parametrised AHB-Lite to APB bridge, the next generation of the fixed three-slave bridge top. It accepts single AHB transfers on the system bus and issues one APB SETUP/ACCESS transaction per transfer. Compared with that bridge it adds:
- configurable address/data width and slave count;
- APB wait states via `pready`;
- error propagation from `pslverr` and from out-of-range addresses as a two-cycle AHB ERROR response;
- an optional access timeout.

---
 rtl/ahb2apb_bridge_param.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ahb2apb_bridge_param.sv
// Parametrised AHB-Lite to APB bridge: one APB SETUP/ACCESS transaction per single AHB transfer.
// Define AHB2APB_TIMEOUT_EN to abort ACCESS phases that see no pready for TIMEOUT cycles.
module ahb2apb_bridge_param #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                NSLV        = 3,
   parameter logic [ADDR_W-1:0] BASE        = 32'h8000_0000,
   parameter int                REGION_BITS = 26
`ifdef AHB2APB_TIMEOUT_EN
   ,
   parameter int                TIMEOUT     = 16
`endif
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hwrite,
   input  logic              hready_in,
   input  logic [1:0]        htrans,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic              hreadyout,
   output logic [1:0]        hresp,
   output logic [DATA_W-1:0] hrdata,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              pwrite,
   output logic [NSLV-1:0]   psel,
   output logic              penable
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WWAIT  = 3'd1,
      S_SETUP  = 3'd2,
      S_ACCESS = 3'd3,
      S_ERR1   = 3'd4,
      S_ERR2   = 3'd5
   } state_t;

   state_t            state_reg;
   state_t            state_next;

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] idx;
   logic              in_range;
   logic              xfer_valid;
   logic              capture;
   logic              read_done;
   logic              timeout_hit;
   logic [NSLV-1:0]   dec_onehot;

   logic [ADDR_W-1:0] paddr_reg;
   logic [DATA_W-1:0] pwdata_reg;
   logic [DATA_W-1:0] hrdata_reg;
   logic              pwrite_reg;
   logic [NSLV-1:0]   sel_reg;

   // Address decode; the subtraction wraps for addresses below BASE, hence the explicit lower bound.
   assign xfer_valid = hready_in && ((htrans == 2'b10) || (htrans == 2'b11));
   assign offset     = haddr - BASE;
   assign idx        = offset >> REGION_BITS;
   assign in_range   = (haddr >= BASE) && (idx < ADDR_W'(NSLV));

   genvar gi;
   generate
      for (gi = 0; gi < NSLV; gi = gi + 1) begin : g_dec
         assign dec_onehot[gi] = (idx == ADDR_W'(gi));
      end
   endgenerate

   assign capture   = (state_reg == S_IDLE) && xfer_valid && in_range;
   assign read_done = (state_reg == S_ACCESS) && pready && !pslverr && !pwrite_reg;

`ifdef AHB2APB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_reg;

   // Counts ACCESS cycles without pready; cleared in SETUP so every ACCESS phase starts at zero.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         to_cnt_reg <= '0;
      end else if (state_reg == S_SETUP) begin
         to_cnt_reg <= '0;
      end else if ((state_reg == S_ACCESS) && !pready) begin
         to_cnt_reg <= to_cnt_reg + 1'b1;
      end
   end

   assign timeout_hit = !pready && (to_cnt_reg == TO_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (xfer_valid) begin
               if (!in_range) begin
                  state_next = S_ERR1;
               end else if (hwrite) begin
                  state_next = S_WWAIT;
               end else begin
                  state_next = S_SETUP;
               end
            end
         end
         S_WWAIT:  state_next = S_SETUP;
         S_SETUP:  state_next = S_ACCESS;
         S_ACCESS: begin
            if (pready) begin
               state_next = pslverr ? S_ERR1 : S_IDLE;
            end else if (timeout_hit) begin
               state_next = S_ERR1;
            end
         end
         S_ERR1:   state_next = S_ERR2;
         S_ERR2:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath registers: each updates only on its own event and otherwise holds.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         paddr_reg  <= '0;
         pwrite_reg <= 1'b0;
         sel_reg    <= '0;
         pwdata_reg <= '0;
         hrdata_reg <= '0;
      end else begin
         if (capture) begin
            paddr_reg  <= haddr;
            pwrite_reg <= hwrite;
            sel_reg    <= dec_onehot;
         end
         if (state_reg == S_WWAIT) begin
            pwdata_reg <= hwdata;
         end
         if (read_done) begin
            hrdata_reg <= prdata;
         end
      end
   end

   always_comb begin
      psel      = '0;
      penable   = 1'b0;
      hreadyout = 1'b1;
      hresp     = 2'b00;
      case (state_reg)
         S_WWAIT: begin
            hreadyout = 1'b0;
         end
         S_SETUP: begin
            psel      = sel_reg;
            hreadyout = 1'b0;
         end
         S_ACCESS: begin
            psel      = sel_reg;
            penable   = 1'b1;
            hreadyout = 1'b0;
         end
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 2'b01;
         end
         S_ERR2: begin
            hresp     = 2'b01;
         end
         default: begin
            hreadyout = 1'b1;
         end
      endcase
   end

   assign paddr  = paddr_reg;
   assign pwdata = pwdata_reg;
   assign pwrite = pwrite_reg;
   assign hrdata = hrdata_reg;

endmodule
